mem_access_unit: RTL

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// Data-memory access unit: issues one bus transaction per load/store and freezes the pipeline until it completes.
// Optional address-map checking is enabled by defining MEM_RANGE_CHECK_EN.
module mem_access_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        Req,
    input  logic [3:0]  MemOp,
    input  logic [31:0] Addr,
    input  logic [31:0] WData,
    input  logic [4:0]  MEM_ExcCode_pre,
    output logic        bus_req,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_we,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic [31:0] MemRData,
    output logic        stall,
    output logic [4:0]  MEM_ExcCode
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned EXC_W  = 5;
    localparam int unsigned BE_W   = 4;

    localparam logic [OP_W-1:0] OP_LW  = 4'd1;
    localparam logic [OP_W-1:0] OP_LH  = 4'd2;
    localparam logic [OP_W-1:0] OP_LHU = 4'd3;
    localparam logic [OP_W-1:0] OP_LB  = 4'd4;
    localparam logic [OP_W-1:0] OP_LBU = 4'd5;
    localparam logic [OP_W-1:0] OP_SW  = 4'd6;
    localparam logic [OP_W-1:0] OP_SH  = 4'd7;
    localparam logic [OP_W-1:0] OP_SB  = 4'd8;

    localparam logic [EXC_W-1:0] EXC_NONE = 5'd0;
    localparam logic [EXC_W-1:0] EXC_ADEL = 5'd4;
    localparam logic [EXC_W-1:0] EXC_ADES = 5'd5;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t state, state_nxt;

    logic              is_load, is_store, is_word, misalign, range_fault, fault, start_c;
    logic [BE_W-1:0]   be_c;
    logic [EXC_W-1:0]  fault_code;
    logic [OP_W-1:0]   op_q;
    logic [1:0]        lane_q;

    // Extend the addressed byte/half of the returned word
    function automatic logic [DATA_W-1:0] load_ext(input logic [OP_W-1:0] op,
                                                   input logic [1:0] lane,
                                                   input logic [DATA_W-1:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        b = rd[{lane, 3'b000} +: 8];
        h = rd[{lane[1], 4'b0000} +: 16];
        case (op)
            OP_LB:   load_ext = {{24{b[7]}}, b};
            OP_LBU:  load_ext = {24'd0, b};
            OP_LH:   load_ext = {{16{h[15]}}, h};
            OP_LHU:  load_ext = {16'd0, h};
            default: load_ext = rd;
        endcase
    endfunction

    // Operation decode: class, alignment and lane enables
    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        is_word  = 1'b0;
        misalign = 1'b0;
        be_c     = '0;
        case (MemOp)
            OP_LW:         begin is_load = 1'b1; is_word = 1'b1; misalign = (Addr[1:0] != 2'b00); end
            OP_LH, OP_LHU: begin is_load = 1'b1; misalign = Addr[0]; end
            OP_LB, OP_LBU: begin is_load = 1'b1; end
            OP_SW:         begin is_store = 1'b1; is_word = 1'b1; misalign = (Addr[1:0] != 2'b00);
                                 be_c = 4'b1111; end
            OP_SH:         begin is_store = 1'b1; misalign = Addr[0]; be_c = 4'b0011 << Addr[1:0]; end
            OP_SB:         begin is_store = 1'b1; be_c = 4'b0001 << Addr[1:0]; end
            default:       ;
        endcase
    end

`ifdef MEM_RANGE_CHECK_EN
    // Only RAM and the two timer register windows are mapped; timers accept word accesses only
    logic in_ram, in_tmr;
    assign in_ram      = (Addr <= 32'h0000_2FFF);
    assign in_tmr      = ((Addr >= 32'h0000_7F00) && (Addr <= 32'h0000_7F0B)) ||
                         ((Addr >= 32'h0000_7F10) && (Addr <= 32'h0000_7F1B));
    assign range_fault = !(in_ram || in_tmr) || (in_tmr && !is_word);
`else
    assign range_fault = 1'b0;
`endif

    assign fault      = (is_load || is_store) && (misalign || range_fault);
    assign fault_code = !fault ? EXC_NONE : (is_load ? EXC_ADEL : EXC_ADES);
    assign start_c    = (state == IDLE) && (is_load || is_store) && (MEM_ExcCode_pre == EXC_NONE)
                        && !fault && !Req;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; Req has no effect once the bus transaction is in flight
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_c) state_nxt = BUSY;
            BUSY:    if (bus_ack) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Combinational outputs
    always_comb begin
        stall       = 1'b0;
        MEM_ExcCode = (MEM_ExcCode_pre != EXC_NONE) ? MEM_ExcCode_pre : fault_code;
        case (state)
            IDLE:    stall = start_c;
            BUSY:    stall = 1'b1;
            default: stall = 1'b0;
        endcase
    end

    // Bus request registers and load result capture
    always_ff @(posedge clk) begin
        if (reset) begin
            bus_req   <= 1'b0;
            bus_addr  <= '0;
            bus_we    <= '0;
            bus_wdata <= '0;
            MemRData  <= '0;
            op_q      <= '0;
            lane_q    <= '0;
        end else begin
            bus_req <= (state_nxt == BUSY);
            if (start_c) begin
                bus_addr  <= {Addr[31:2], 2'b00};
                bus_we    <= be_c;
                bus_wdata <= WData << {Addr[1:0], 3'b000};
                op_q      <= MemOp;
                lane_q    <= Addr[1:0];
            end
            if ((state == BUSY) && bus_ack)
                MemRData <= load_ext(op_q, lane_q, bus_rdata);
        end
    end

endmodule
